id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the vector CPU. It registers the decoded control word from the control unit together with the register-file read data, immediate and register indices into the E stage. It inserts bubbles for flush and for load-use hazards, and it drives the fetch/decode stall lines. It sits directly downstream of the control unit and register files, and upstream of the scalar/vector ALUs.

---
 rtl/id_ex_stage_if.sv | 55 +++++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: D-side inputs, E-side registered outputs and the stall/hold/flush
// lines of the decode-to-execute stage.
// Ports: master = upstream/control driver (drives D signals, holdE, flushE);
//        slave  = the stage itself (drives E signals, stallF, stallD).
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANES          = 4,
  parameter int REG_ADDR_WIDTH = 4
);
  localparam int VW = LANES * DATA_WIDTH;

  // decode side
  logic                      validD;
  logic                      useScalarAluD, isScalarOutputD, isScalarReg1D, isScalarReg2D;
  logic                      resultSelectorWBD, writeEnableScalarWBD, writeEnableVectorWBD;
  logic                      writeToMemoryEnableMD, useInmediateD, outFlagMD;
  logic [3:0]                aluControlD;
  logic [DATA_WIDTH-1:0]     srcA_D, srcB_D, immD;
  logic [VW-1:0]             vecA_D, vecB_D;
  logic [REG_ADDR_WIDTH-1:0] rs1D, rs2D, rdD;
  logic                      holdE, flushE;

  // execute side
  logic                      validE;
  logic                      useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E;
  logic                      resultSelectorWBE, writeEnableScalarWBE, writeEnableVectorWBE;
  logic                      writeToMemoryEnableME, useInmediateE, outFlagME;
  logic [3:0]                aluControlE;
  logic [DATA_WIDTH-1:0]     srcA_E, srcB_E, immE;
  logic [VW-1:0]             vecA_E, vecB_E;
  logic [REG_ADDR_WIDTH-1:0] rs1E, rs2E, rdE;
  logic                      stallF, stallD;

  modport master (
    output validD, useScalarAluD, isScalarOutputD, isScalarReg1D, isScalarReg2D,
           resultSelectorWBD, writeEnableScalarWBD, writeEnableVectorWBD,
           writeToMemoryEnableMD, useInmediateD, outFlagMD, aluControlD,
           srcA_D, srcB_D, immD, vecA_D, vecB_D, rs1D, rs2D, rdD, holdE, flushE,
    input  validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E,
           resultSelectorWBE, writeEnableScalarWBE, writeEnableVectorWBE,
           writeToMemoryEnableME, useInmediateE, outFlagME, aluControlE,
           srcA_E, srcB_E, immE, vecA_E, vecB_E, rs1E, rs2E, rdE, stallF, stallD
  );

  modport slave (
    input  validD, useScalarAluD, isScalarOutputD, isScalarReg1D, isScalarReg2D,
           resultSelectorWBD, writeEnableScalarWBD, writeEnableVectorWBD,
           writeToMemoryEnableMD, useInmediateD, outFlagMD, aluControlD,
           srcA_D, srcB_D, immD, vecA_D, vecB_D, rs1D, rs2D, rdD, holdE, flushE,
    output validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E,
           resultSelectorWBE, writeEnableScalarWBE, writeEnableVectorWBE,
           writeToMemoryEnableME, useInmediateE, outFlagME, aluControlE,
           srcA_E, srcB_E, immE, vecA_E, vecB_E, rs1E, rs2E, rdE, stallF, stallD
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: registers the decoded control word, register read data, immediate and
// register indices from D into E (one cycle), inserting bubbles on flush and load-use.
// Ports: clk, reset (synchronous, active-low), bus (id_ex_stage_if.slave).
// Optional load-use detection is built when ID_EX_HAZARD_DETECT_EN is defined;
// otherwise stalls come only from holdE and LOAD_BUBBLES is ignored.
module id_ex_stage #(
  parameter int LOAD_BUBBLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3) begin : g_bad_load_bubbles
    $error("id_ex_stage: LOAD_BUBBLES must be in 1..3");
  end

  logic take_bubble;  // E becomes a bubble on this edge
  logic take_d;       // E captures the D instruction on this edge

`ifdef ID_EX_HAZARD_DETECT_EN
  logic       hazD;
  logic [1:0] bcnt;   // bubbles still owed after the current one; nonzero = STALL

  // Only a vector load in E can hurt a vector read in D; scalar writers are
  // forwarded elsewhere, and rs2 is unused when the immediate replaces it.
  always_comb begin
    hazD = bus.validD & bus.validE & bus.resultSelectorWBE & bus.writeEnableVectorWBE &
           (((bus.rdE == bus.rs1D) & ~bus.isScalarReg1D) |
            ((bus.rdE == bus.rs2D) & ~bus.isScalarReg2D & ~bus.useInmediateD));
  end

  always_comb begin
    take_bubble = bus.flushE | (~bus.holdE & ((bcnt != 2'd0) | hazD));
    take_d      = ~bus.flushE & ~bus.holdE & (bcnt == 2'd0) & ~hazD;
    // hazD only matters in IDLE, and in STALL the bcnt term already stalls.
    bus.stallD  = ~bus.flushE & (bus.holdE | (bcnt != 2'd0) | hazD);
    bus.stallF  = bus.stallD;
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.flushE) begin
      bcnt <= 2'd0;
    end else if (bus.holdE) begin
      bcnt <= bcnt;
    end else if (bcnt != 2'd0) begin
      bcnt <= bcnt - 2'd1;
    end else if (hazD) begin
      // The bubble inserted on this edge is the first of LOAD_BUBBLES.
      bcnt <= 2'(LOAD_BUBBLES - 1);
    end
  end
`else
  always_comb begin
    take_bubble = bus.flushE;
    take_d      = ~bus.flushE & ~bus.holdE;
    bus.stallD  = ~bus.flushE & bus.holdE;
    bus.stallF  = bus.stallD;
  end
`endif

  // E register; neither take_bubble nor take_d means hold.
  always_ff @(posedge clk) begin
    if (!reset || take_bubble) begin
      bus.validE                <= 1'b0;
      bus.useScalarAluE         <= 1'b0;
      bus.isScalarOutputE       <= 1'b0;
      bus.isScalarReg1E         <= 1'b0;
      bus.isScalarReg2E         <= 1'b0;
      bus.resultSelectorWBE     <= 1'b0;
      bus.writeEnableScalarWBE  <= 1'b0;
      bus.writeEnableVectorWBE  <= 1'b0;
      bus.writeToMemoryEnableME <= 1'b0;
      bus.useInmediateE         <= 1'b0;
      bus.outFlagME             <= 1'b0;
      bus.aluControlE           <= '0;
      bus.srcA_E                <= '0;
      bus.srcB_E                <= '0;
      bus.immE                  <= '0;
      bus.vecA_E                <= '0;
      bus.vecB_E                <= '0;
      bus.rs1E                  <= '0;
      bus.rs2E                  <= '0;
      bus.rdE                   <= '0;
    end else if (take_d) begin
      bus.validE                <= bus.validD;
      bus.useScalarAluE         <= bus.useScalarAluD;
      bus.isScalarOutputE       <= bus.isScalarOutputD;
      bus.isScalarReg1E         <= bus.isScalarReg1D;
      bus.isScalarReg2E         <= bus.isScalarReg2D;
      bus.resultSelectorWBE     <= bus.resultSelectorWBD;
      bus.writeEnableScalarWBE  <= bus.writeEnableScalarWBD;
      bus.writeEnableVectorWBE  <= bus.writeEnableVectorWBD;
      bus.writeToMemoryEnableME <= bus.writeToMemoryEnableMD;
      bus.useInmediateE         <= bus.useInmediateD;
      bus.outFlagME             <= bus.outFlagMD;
      bus.aluControlE           <= bus.aluControlD;
      bus.srcA_E                <= bus.srcA_D;
      bus.srcB_E                <= bus.srcB_D;
      bus.immE                  <= bus.immD;
      bus.vecA_E                <= bus.vecA_D;
      bus.vecB_E                <= bus.vecB_D;
      bus.rs1E                  <= bus.rs1D;
      bus.rs2E                  <= bus.rs2D;
      bus.rdE                   <= bus.rdD;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized stimulus for id_ex_stage, checked against
// an instruction-level reference model (E contents plus bubbles still owed).
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int RW = 4;
  localparam int LB = 2;
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic              use_salu, s_out, s_reg1, s_reg2, res_sel, we_s, we_v, we_m, use_imm, out_flag;
    logic [3:0]        alu;
    logic [DW-1:0]     src_a, src_b, imm;
    logic [LN*DW-1:0]  vec_a, vec_b;
    logic [RW-1:0]     rs1, rs2, rd;
  } instr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(DW), .LANES(LN), .REG_ADDR_WIDTH(RW)) bus ();
  id_ex_stage #(.LOAD_BUBBLES(LB)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: what E should hold and how many more bubbles the load owes
  instr_t exp_e;
  int     owed  = 0;
  bit     known = 0;
  logic   last_stall;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ctrl_of(input instr_t i);
    return {i.use_salu, i.s_out, i.s_reg1, i.s_reg2, i.res_sel, i.we_s, i.we_v, i.we_m,
            i.use_imm, i.out_flag, i.alu};
  endfunction

  function automatic logic [363:0] data_of(input instr_t i);
    return {i.src_a, i.src_b, i.imm, i.vec_a, i.vec_b, i.rs1, i.rs2, i.rd};
  endfunction

  function automatic instr_t read_e();
    instr_t e;
    e = '{valid: bus.validE, use_salu: bus.useScalarAluE, s_out: bus.isScalarOutputE,
          s_reg1: bus.isScalarReg1E, s_reg2: bus.isScalarReg2E, res_sel: bus.resultSelectorWBE,
          we_s: bus.writeEnableScalarWBE, we_v: bus.writeEnableVectorWBE,
          we_m: bus.writeToMemoryEnableME, use_imm: bus.useInmediateE, out_flag: bus.outFlagME,
          alu: bus.aluControlE, src_a: bus.srcA_E, src_b: bus.srcB_E, imm: bus.immE,
          vec_a: bus.vecA_E, vec_b: bus.vecB_E, rs1: bus.rs1E, rs2: bus.rs2E, rd: bus.rdE};
    return e;
  endfunction

  task automatic drive(input instr_t d);
    bus.validD = d.valid;               bus.useScalarAluD = d.use_salu;
    bus.isScalarOutputD = d.s_out;      bus.isScalarReg1D = d.s_reg1;
    bus.isScalarReg2D = d.s_reg2;       bus.resultSelectorWBD = d.res_sel;
    bus.writeEnableScalarWBD = d.we_s;  bus.writeEnableVectorWBD = d.we_v;
    bus.writeToMemoryEnableMD = d.we_m; bus.useInmediateD = d.use_imm;
    bus.outFlagMD = d.out_flag;         bus.aluControlD = d.alu;
    bus.srcA_D = d.src_a; bus.srcB_D = d.src_b; bus.immD = d.imm;
    bus.vecA_D = d.vec_a; bus.vecB_D = d.vec_b;
    bus.rs1D = d.rs1; bus.rs2D = d.rs2; bus.rdD = d.rd;
  endtask

  // One clock: present D/hold/flush, check stalls, clock, advance model, check E.
  task automatic step(input instr_t d, input logic h, input logic f);
    bit haz, want_stall;
    instr_t e;
    drive(d);
    bus.holdE = h;
    bus.flushE = f;
    #1;
    // a vector load sitting in E blocks a D instruction reading its destination as a vector
    haz = HAZ_EN && d.valid && exp_e.valid && exp_e.res_sel && exp_e.we_v &&
          ((exp_e.rd == d.rs1 && !d.s_reg1) || (exp_e.rd == d.rs2 && !d.s_reg2 && !d.use_imm));
    want_stall = !f && (h || owed > 0 || haz);
    last_stall = bus.stallD;
    if (known) begin
      check_val("stallD", 512'(bus.stallD), 512'(want_stall));
      check_val("stallF", 512'(bus.stallF), 512'(want_stall));
    end
    @(posedge clk);
    if (!reset || f) begin
      exp_e = '0; owed = 0; known = known || !reset;
    end else if (h) begin
      // frozen
    end else if (owed > 0) begin
      exp_e = '0; owed--;
    end else if (haz) begin
      exp_e = '0; owed = LB - 1;
    end else begin
      exp_e = d;
    end
    #1;
    if (known) begin
      e = read_e();
      check_val("validE", 512'(e.valid), 512'(exp_e.valid));
      check_val("ctrlE",  512'(ctrl_of(e)), 512'(ctrl_of(exp_e)));
      check_val("dataE",  512'(data_of(e)), 512'(data_of(exp_e)));
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r = '0;
    r.valid = ($urandom_range(0, 5) != 0);
    {r.use_salu, r.s_out, r.s_reg1, r.s_reg2, r.we_s, r.we_m, r.use_imm, r.out_flag} = 8'($urandom);
    r.res_sel = ($urandom_range(0, 2) != 0);
    r.we_v    = ($urandom_range(0, 2) != 0);
    r.alu = 4'($urandom);
    r.src_a = $urandom; r.src_b = $urandom; r.imm = $urandom;
    r.vec_a = {$urandom, $urandom, $urandom, $urandom};
    r.vec_b = {$urandom, $urandom, $urandom, $urandom};
    r.rs1 = 4'($urandom_range(0, 3)); r.rs2 = 4'($urandom_range(0, 3)); r.rd = 4'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic instr_t vldr(input logic [3:0] rd);
    instr_t r;
    r = '0; r.valid = 1; r.res_sel = 1; r.we_v = 1; r.alu = 4'h0; r.rd = rd; r.rs1 = 4'hf;
    r.rs2 = 4'hf; r.s_reg1 = 1; r.s_reg2 = 1;
    return r;
  endfunction

  function automatic instr_t vadd(input logic [3:0] rs1, input logic [3:0] rd);
    instr_t r;
    r = '0; r.valid = 1; r.we_v = 1; r.alu = 4'h1; r.rs1 = rs1; r.rs2 = 4'he; r.s_reg2 = 1;
    r.rd = rd; r.vec_a = {32'd4, 32'd3, 32'd2, 32'd1}; r.vec_b = {4{32'h10}};
    return r;
  endfunction

  // Present `d` until accepted; returns how many cycles it was stalled.
  task automatic present_until_taken(input instr_t d, output int stalls);
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      step(d, 1'b0, 1'b0);
      if (last_stall !== 1'b1) return;
      stalls++;
    end
    check_val("accept_timeout", 512'(1), 512'(0));
  endtask

  initial begin
    instr_t d;
    instr_t e;
    int stalls;
    exp_e = '0;

    // reset with a live instruction in D
    d = '0; d.valid = 1; d.alu = 4'b0100;
    reset = 1'b0;
    step(d, 1'b0, 1'b0);
    step(d, 1'b0, 1'b0);
    e = read_e();
    check_val("reset_validE", 512'(e.valid), 512'(0));
    check_val("reset_alu", 512'(e.alu), 512'(0));
    check_val("reset_wev", 512'(e.we_v), 512'(0));
    reset = 1'b1;
    step(d, 1'b0, 1'b0);
    e = read_e();
    check_val("post_reset_validE", 512'(e.valid), 512'(1));
    check_val("post_reset_alu", 512'(e.alu), 512'(4'b0100));

    // pass-through
    step(vadd(4'd7, 4'd3), 1'b0, 1'b0);
    e = read_e();
    check_val("pass_rd", 512'(e.rd), 512'(3));
    check_val("pass_veca", 512'(e.vec_a), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
    check_val("pass_stall", 512'(last_stall), 512'(0));

    // load-use on rs1
    step(vldr(4'd5), 1'b0, 1'b0);
    present_until_taken(vadd(4'd5, 4'd9), stalls);
    check_val("loaduse_stalls", 512'(stalls), 512'(HAZ_EN ? LB : 0));
    e = read_e();
    check_val("loaduse_consumer", 512'(e.rd), 512'(9));
    // independent register
    step(vldr(4'd5), 1'b0, 1'b0);
    present_until_taken(vadd(4'd6, 4'd9), stalls);
    check_val("nodep_stalls", 512'(stalls), 512'(0));

    // immediate replaces rs2, rs1 read as scalar
    step(vldr(4'd2), 1'b0, 1'b0);
    d = vadd(4'd2, 4'd8); d.rs2 = 4'd2; d.s_reg2 = 0; d.use_imm = 1; d.s_reg1 = 1; d.alu = 4'h3;
    step(d, 1'b0, 1'b0);
    check_val("imm_exempt_stall", 512'(last_stall), 512'(0));

    // flush beats hazard, and beats hold
    step(vldr(4'd5), 1'b0, 1'b0);
    step(vadd(4'd5, 4'd1), 1'b0, 1'b1);
    check_val("flush_stall", 512'(last_stall), 512'(0));
    check_val("flush_validE", 512'(bus.validE), 512'(0));
    step(vldr(4'd5), 1'b0, 1'b0);
    step(vadd(4'd5, 4'd1), 1'b1, 1'b1);
    check_val("flush_hold_stall", 512'(last_stall), 512'(0));
    check_val("flush_hold_validE", 512'(bus.validE), 512'(0));

    // hold in the middle of a load-use stall, then plain hold
    step(vldr(4'd4), 1'b0, 1'b0);
    step(vadd(4'd4, 4'd2), 1'b0, 1'b0);
    step(vadd(4'd4, 4'd2), 1'b1, 1'b0);
    step(vadd(4'd4, 4'd2), 1'b1, 1'b0);
    present_until_taken(vadd(4'd4, 4'd2), stalls);
    check_val("hold_stall_rest", 512'(stalls), 512'(HAZ_EN ? LB - 1 : 0));
    step(vadd(4'd1, 4'd6), 1'b1, 1'b0);
    check_val("hold_stallD", 512'(last_stall), 512'(1));
    check_val("hold_frozen_rd", 512'(bus.rdE), 512'(2));

    // reset in the middle of a stall
    step(vldr(4'd3), 1'b0, 1'b0);
    step(vadd(4'd3, 4'd2), 1'b0, 1'b0);
    reset = 1'b0;
    step(vadd(4'd3, 4'd2), 1'b0, 1'b0);
    reset = 1'b1;
    step(vadd(4'd3, 4'd2), 1'b0, 1'b0);
    check_val("reset_abort_stall", 512'(last_stall), 512'(0));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      step(rand_instr(), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
